// File: rtl/fifo_umbrales.sv
// fifo_umbrales: 8-deep per-VC FIFO with programmable almost-full/empty flags.
// Ports: clk, reset, push/data_in, pop, umbral_superior/inferior -> data_out, valid, count, empty, full, almost_*, fifo_error.
module fifo_umbrales #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [2:0]            umbral_superior,
  input  logic [2:0]            umbral_inferior,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0]         C_ONE  = CW'(1);
  localparam logic [CW-1:0]         C_FULL = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] P_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic pop_ok;
  logic push_ok;
  logic err_evt;
  logic [CW-1:0] sup_ext;
  logic [CW-1:0] inf_ext;

  assign empty = (count == '0);
  assign full  = (count == C_FULL);

  // No bypass: a pop on an empty FIFO is rejected even with push.
  // A full FIFO still takes a push when a pop frees a slot.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign err_evt = (push && !push_ok) || (pop && empty);

  assign sup_ext = CW'(umbral_superior);
  assign inf_ext = CW'(umbral_inferior);

  // Threshold 0 would make almost_full constantly high; fall back to full.
  assign almost_full  = (umbral_superior == '0) ? full
                                                : (count >= sup_ext);
  assign almost_empty = (count <= inf_ext);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      fifo_error <= 1'b0;
    end else begin
      valid <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + P_ONE;
      end
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + P_ONE;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
      if (err_evt) begin
        fifo_error <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fifo_umbrales.md
# fifo_umbrales

Per-virtual-channel buffer of the transaction layer, depth 8, with programmable almost-full/almost-empty flags. It sits directly downstream of the threshold/state-control FSM and takes its latched `Umbral_superior`/`Umbral_inferior` values as threshold inputs. Its `empty` output is one bit of the 8-bit `Empties` bus that the FSM watches to move between IDLE and ACTIVE. Eight instances form the FIFO bank; flow control upstream uses `almost_full`, downstream arbitration uses `almost_empty`.

## Interface
- `DATA_WIDTH`, 6, width of stored words
- `ADDR_WIDTH`, 3, pointer width; depth = 2**ADDR_WIDTH = 8
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately, released synchronously by the system
- `push`  in  1  write request, `data_in` sampled on same edge
- `data_in`  in  DATA_WIDTH  write data
- `pop`  in  1  read request
- `umbral_superior`  in  3  almost-full threshold (from FSM `Umbral_superior`)
- `umbral_inferior`  in  3  almost-empty threshold (from FSM `Umbral_inferior`)
- `data_out`  out  DATA_WIDTH  registered read data
- `valid`  out  1  `data_out` holds a newly popped word this cycle
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..8
- `empty`  out  1  count == 0
- `full`  out  1  count == 8
- `almost_full`  out  1  see Operation
- `almost_empty`  out  1  see Operation
- `fifo_error`  out  1  sticky overflow/underflow indicator

## Operation
- Storage: 8 x DATA_WIDTH array, write pointer `wr_ptr` and read pointer `rd_ptr` (ADDR_WIDTH bits, natural wrap 7->0), occupancy counter `count` (4 bits).
- Accepted push: `push && (!full || pop_accepted)`; writes `mem[wr_ptr]`, `wr_ptr` +1.
- Accepted pop: `pop && !empty`; `data_out <= mem[rd_ptr]`, `valid <= 1`, `rd_ptr` +1. Otherwise `valid <= 0`, `data_out` holds.
- `count` next = count + accepted push − accepted pop.
- Push and pop together:
  - Count in 1..7: both accepted, count unchanged.
  - Full: both accepted, count stays 8, no error.
  - Empty: push accepted, pop rejected (no bypass), underflow error.
- Push while full without pop: dropped; memory and pointers unchanged; `fifo_error` set.
- Pop while empty: rejected; `valid` 0; `fifo_error` set.
- `fifo_error` stays 1 until `reset`.
- Flags are combinational decodes of the registered `count` and the threshold inputs:
  - `almost_full` = (umbral_superior == 0) ? full : (count >= umbral_superior).
  - `almost_empty` = (count <= umbral_inferior); with umbral_inferior == 0 this equals `empty`.
- Threshold comparisons are zero-extended to 4 bits.
- Threshold inputs may change at any time; flags follow combinationally, and no stored state depends on them.
- Reset values: pointers 0, count 0, `data_out` 0, `valid` 0, `fifo_error` 0, `empty` 1, `full` 0, `almost_full` 0, `almost_empty` 1.
- Reset asserted mid-operation discards all contents. Memory array contents need not be cleared but are unreachable until rewritten.

## Timing
- Write latency: push at edge N updates `count`/flags after edge N. The earliest accepted pop is at edge N+1, with `data_out`/`valid` visible after N+1.
- Read latency: one cycle from pop-sampling edge to `data_out`; `valid` is a single-cycle pulse per accepted pop.
- Back-to-back pops on consecutive edges stream one word per cycle with `valid` held high.
- `empty` falls after the first accepted push edge. The FSM sees its `Empties` bit change the same cycle and moves to ACTIVE one edge later.
- Asynchronous reset takes effect without a clock edge; outputs reach reset values within the same cycle.

## Test plan
- Reset then idle: assert `reset` mid-cycle -> immediately count=0, empty=1, almost_empty=1, full=0, valid=0, fifo_error=0.
- Fill/drain with umbral_superior=6, umbral_inferior=2: push 0x01..0x08 -> almost_full rises after 6th push and full after 8th. Then pop 8 -> data_out 0x01..0x08 in order, each with valid=1 one cycle after its pop. almost_empty rises when count reaches 2; empty rises after the last pop; fifo_error=0 throughout.
- Overflow: fill to 8, push 0x3F alone -> count stays 8, fifo_error=1. A subsequent full drain returns the original 8 words, not 0x3F.
- Underflow and empty push+pop: on empty FIFO assert push=pop=1 with 0x15 -> count=1, valid=0, fifo_error=1. Next pop yields 0x15.
- Full push+pop plus wrap-around: fill to 8, pop 3, push 3, then push+pop together for 10 cycles -> count stays 8, FIFO order preserved across pointer wrap, no error.
- Threshold edge cases and reset mid-stream: umbral_superior=0 -> almost_full tracks full exactly; umbral_inferior=0 -> almost_empty equals empty. Assert reset with count=5 -> all outputs return to reset values the same cycle.
